// File: rtl/regfile_dump_unit.sv
// Streams x0..x(NUM_REGS-1) from a spare async register-file read port out on a valid/ready beat interface.
// Optional trailing XOR checksum beat when REGFILE_DUMP_CHECKSUM_EN is defined.
module regfile_dump_unit #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [ADDR_W-1:0] m_idx_o,
  output logic              m_last_o
);

  typedef enum logic [1:0] {IDLE, SEND, CSUM, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]   m_data_q;
  logic [ADDR_W-1:0]   m_idx_q;
  logic                m_valid_q;
  logic                m_last_q;
  logic                busy_q;
  logic                done_q;
  logic                fire;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q;
`endif

  assign fire = m_valid_q & m_ready_i;

  // Look one register ahead on a fire so the next beat is captured in the same edge.
  always_comb begin
    rf_addr_o = '0;
    if (state_q == SEND) begin
      rf_addr_o = fire ? idx_q + 1'b1 : idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      m_data_q  <= '0;
      m_idx_q   <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            m_data_q  <= rf_data_i;
            m_idx_q   <= '0;
            idx_q     <= '0;
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q    <= '0;
`endif
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (fire) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q <= csum_q ^ m_data_q;
`endif
            if (idx_q != LAST_IDX) begin
              idx_q    <= idx_q + 1'b1;
              m_idx_q  <= idx_q + 1'b1;
              m_data_q <= rf_data_i;
`ifdef REGFILE_DUMP_CHECKSUM_EN
              m_last_q <= 1'b0;
`else
              m_last_q <= ((idx_q + 1'b1) == LAST_IDX);
`endif
            end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              m_data_q <= csum_q ^ m_data_q;
              m_idx_q  <= '0;
              m_last_q <= 1'b1;
              state_q  <= CSUM;
`else
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= DONE;
`endif
            end
          end
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        CSUM: begin
          if (fire) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
`endif
        DONE: begin
          done_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_idx_o   = m_idx_q;
  assign m_last_o  = m_last_q;

endmodule
